// File: rtl/fp_pkg.sv
// Shared widths, rounding modes and constants for the single-precision
// multiplier output stage.
package fp_pkg;

    localparam int unsigned IN_EXP_W = 10;
    localparam int unsigned EXP_W    = 12;
    localparam int unsigned MANT_W   = 48;
    localparam int unsigned FRAC_W   = 23;
    localparam int unsigned EXP_BIAS = 127;
    localparam int unsigned EXP_OVF  = 2 * EXP_BIAS + 1;

    localparam logic [31:0] FP_QNAN        = 32'h7FC00000;
    localparam logic [30:0] FP_MAXNORM_MAG = 31'h7F7FFFFF;
    localparam logic [30:0] FP_MINNORM_MAG = 31'h00800000;
    localparam logic [30:0] FP_INF_MAG     = 31'h7F800000;

    typedef enum logic [2:0] {
        IEEE_near = 3'd0,
        IEEE_zero = 3'd1,
        IEEE_pinf = 3'd2,
        IEEE_ninf = 3'd3,
        near_up   = 3'd4,
        away_zero = 3'd5
    } round_mode_t;

    typedef struct packed {
        logic zero;
        logic inf;
        logic nan;
        logic tiny;
        logic huge;
    } status_t;

    // Rounded result plus operand class, carried from stage 1 to stage 2.
    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
        logic              a_zero;
        logic              a_inf;
        logic              b_zero;
        logic              b_inf;
        round_mode_t       rnd;
    } s1_t;

endpackage

// File: rtl/fp_mult_round_status_if.sv
// Core-to-output-stage beat plus result/status handshake.
// FP_ROUND_INEXACT_EN adds the inexact_f status bit.
interface fp_mult_round_status_if;
    import fp_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic                in_sign;
    logic [IN_EXP_W-1:0] in_exp;
    logic [MANT_W-1:0]   in_mant;
    logic                in_a_zero;
    logic                in_a_inf;
    logic                in_b_zero;
    logic                in_b_inf;
    logic [2:0]          rnd;
    logic                out_valid;
    logic                out_ready;
    logic [31:0]         z;
    logic                zero_f;
    logic                inf_f;
    logic                nan_f;
    logic                tiny_f;
    logic                huge_f;
`ifdef FP_ROUND_INEXACT_EN
    logic                inexact_f;
`endif

    modport master (
        output in_valid, in_sign, in_exp, in_mant, in_a_zero, in_a_inf,
               in_b_zero, in_b_inf, rnd, out_ready,
        input  in_ready, out_valid, z, zero_f, inf_f, nan_f, tiny_f, huge_f
`ifdef FP_ROUND_INEXACT_EN
      , input  inexact_f
`endif
    );

    modport slave (
        input  in_valid, in_sign, in_exp, in_mant, in_a_zero, in_a_inf,
               in_b_zero, in_b_inf, rnd, out_ready,
        output in_ready, out_valid, z, zero_f, inf_f, nan_f, tiny_f, huge_f
`ifdef FP_ROUND_INEXACT_EN
      , output inexact_f
`endif
    );

endinterface

// File: rtl/fp_round_decide.sv
// Rounding increment decision from sign, lsb, guard/round/sticky and mode.
module fp_round_decide
    import fp_pkg::*;
(
    input  logic        sign_i,
    input  logic        lsb_i,
    input  logic        g_i,
    input  logic        r_i,
    input  logic        s_i,
    input  round_mode_t mode_i,
    output logic        inc_c_o
);

    logic any_c;

    always_comb begin
        any_c   = g_i | r_i | s_i;
        inc_c_o = 1'b0;
        case (mode_i)
            IEEE_near: inc_c_o = g_i & (r_i | s_i | lsb_i);
            near_up:   inc_c_o = g_i;
            away_zero: inc_c_o = any_c;
            IEEE_pinf: inc_c_o = any_c & ~sign_i;
            IEEE_ninf: inc_c_o = any_c & sign_i;
            default:   inc_c_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/fp_mult_round_status.sv
// Multiplier output stage: normalise/round, then resolve exceptions and flags.
// FP_ROUND_INEXACT_EN adds the inexact_f status output.
module fp_mult_round_status
    import fp_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    fp_mult_round_status_if.slave        bus
);

    logic              adv_c;
    logic [FRAC_W-1:0] frac_c;
    logic              g_c, r_c, s_c, inc_c;
    logic [FRAC_W:0]   sum_c;
    round_mode_t       mode_c;
    s1_t               s1_d, s1_q;
    logic              s1_valid_q;
    logic              nan_op_c, inf_op_c, zero_op_c, ovf_c, udf_c;
    logic [31:0]       z_d, z_q;
    status_t           flags_d, flags_q;
    logic              out_valid_q;

    // Whole pipe advances together; a full pipe refills in the same cycle it drains.
    assign adv_c        = !out_valid_q || bus.out_ready;
    assign bus.in_ready = adv_c;
    assign mode_c       = round_mode_t'(bus.rnd);

    // Product in [2,4) drops one extra bit into the round position.
    always_comb begin
        if (bus.in_mant[MANT_W-1]) begin
            frac_c = bus.in_mant[46:24];
            g_c    = bus.in_mant[23];
            r_c    = bus.in_mant[22];
            s_c    = |bus.in_mant[21:0];
        end else begin
            frac_c = bus.in_mant[45:23];
            g_c    = bus.in_mant[22];
            r_c    = bus.in_mant[21];
            s_c    = |bus.in_mant[20:0];
        end
    end

    fp_round_decide u_round (
        .sign_i  (bus.in_sign),
        .lsb_i   (frac_c[0]),
        .g_i     (g_c),
        .r_i     (r_c),
        .s_i     (s_c),
        .mode_i  (mode_c),
        .inc_c_o (inc_c)
    );

    // Fraction carry-out means the significand rounded up to 2.0.
    always_comb begin
        sum_c       = {1'b0, frac_c} + (FRAC_W + 1)'(inc_c);
        s1_d.sign   = bus.in_sign;
        s1_d.exp    = EXP_W'($signed(bus.in_exp)) + EXP_W'(bus.in_mant[MANT_W-1])
                    + EXP_W'(sum_c[FRAC_W]);
        s1_d.frac   = sum_c[FRAC_W-1:0];
        s1_d.a_zero = bus.in_a_zero;
        s1_d.a_inf  = bus.in_a_inf;
        s1_d.b_zero = bus.in_b_zero;
        s1_d.b_inf  = bus.in_b_inf;
        s1_d.rnd    = mode_c;
    end

    assign nan_op_c  = (s1_q.a_zero & s1_q.b_inf) | (s1_q.a_inf & s1_q.b_zero);
    assign inf_op_c  = s1_q.a_inf | s1_q.b_inf;
    assign zero_op_c = s1_q.a_zero | s1_q.b_zero;
    assign ovf_c     = !s1_q.exp[EXP_W-1] && (s1_q.exp >= EXP_W'(EXP_OVF));
    assign udf_c     = s1_q.exp[EXP_W-1] || (s1_q.exp == '0);

    // Exception rows in priority order; flags are forced low on a bubble.
    always_comb begin
        z_d     = {s1_q.sign, s1_q.exp[7:0], s1_q.frac};
        flags_d = '0;
        if (nan_op_c) begin
            z_d         = FP_QNAN;
            flags_d.nan = 1'b1;
        end else if (inf_op_c) begin
            z_d         = {s1_q.sign, FP_INF_MAG};
            flags_d.inf = 1'b1;
        end else if (zero_op_c) begin
            z_d          = {s1_q.sign, 31'h0};
            flags_d.zero = 1'b1;
        end else if (ovf_c) begin
            flags_d.huge = 1'b1;
            if (s1_q.rnd == IEEE_zero || (s1_q.rnd == IEEE_pinf && s1_q.sign)
                || (s1_q.rnd == IEEE_ninf && !s1_q.sign)) begin
                z_d = {s1_q.sign, FP_MAXNORM_MAG};
            end else begin
                z_d         = {s1_q.sign, FP_INF_MAG};
                flags_d.inf = 1'b1;
            end
        end else if (udf_c) begin
            flags_d.tiny = 1'b1;
            if (s1_q.rnd == away_zero || (s1_q.rnd == IEEE_pinf && !s1_q.sign)
                || (s1_q.rnd == IEEE_ninf && s1_q.sign)) begin
                z_d = {s1_q.sign, FP_MINNORM_MAG};
            end else begin
                z_d          = {s1_q.sign, 31'h0};
                flags_d.zero = 1'b1;
            end
        end
        if (!s1_valid_q) begin
            flags_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_q        <= '0;
            out_valid_q <= 1'b0;
            z_q         <= '0;
            flags_q     <= '0;
        end else if (adv_c) begin
            s1_valid_q  <= bus.in_valid;
            s1_q        <= s1_d;
            out_valid_q <= s1_valid_q;
            z_q         <= z_d;
            flags_q     <= flags_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.z         = z_q;
    assign bus.zero_f    = flags_q.zero;
    assign bus.inf_f     = flags_q.inf;
    assign bus.nan_f     = flags_q.nan;
    assign bus.tiny_f    = flags_q.tiny;
    assign bus.huge_f    = flags_q.huge;

`ifdef FP_ROUND_INEXACT_EN
    logic s1_inexact_q, inexact_d, inexact_q;

    always_comb begin
        inexact_d = 1'b0;
        if (s1_valid_q && !nan_op_c && !inf_op_c && !zero_op_c) begin
            inexact_d = ovf_c || udf_c || s1_inexact_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_inexact_q <= 1'b0;
            inexact_q    <= 1'b0;
        end else if (adv_c) begin
            s1_inexact_q <= g_c | r_c | s_c;
            inexact_q    <= inexact_d;
        end
    end

    assign bus.inexact_f = inexact_q;
`endif

endmodule

// File: tb/tb_fp_mult_round_status.sv
// Bench for fp_mult_round_status: exact-arithmetic reference model, queue
// scoreboard, stall/hold and flush checks.
module tb_fp_mult_round_status;
    import fp_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fp_mult_round_status_if bus ();
    fp_mult_round_status dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] z;
        logic zf, inff, nanf, tinyf, hugef, inex;
    } exp_t;

    exp_t exp_q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: exact integer rounding by comparing the discarded remainder to half an ulp.
    function automatic exp_t model(input logic sgn, input int e_in, input logic [47:0] mant,
                                   input logic [3:0] cls, input int mode);
        exp_t   r;
        longint m, q, rem, half;
        int     k, e;
        bit     inc, inex, az, ai, bz, bi, to_inf, to_min;
        r = '0;
        {az, ai, bz, bi} = cls;
        m = longint'(mant);
        e = e_in;
        if (mant >= 48'h800000000000) begin k = 24; e = e + 1; end
        else k = 23;
        q    = m >> k;
        rem  = m - (q << k);
        half = longint'(1) << (k - 1);
        inex = (rem != 0);
        case (mode)
            0:       inc = (rem > half) || (rem == half && (q % 2) == 1);
            4:       inc = (rem >= half);
            5:       inc = inex;
            2:       inc = inex && !sgn;
            3:       inc = inex && sgn;
            default: inc = 1'b0;
        endcase
        q = q + longint'(inc);
        if (q == (longint'(1) << 24)) begin q = longint'(1) << 23; e = e + 1; end
        if ((az && bi) || (ai && bz)) begin
            r.z = 32'h7FC00000; r.nanf = 1'b1;
        end else if (ai || bi) begin
            r.z = {sgn, 8'hFF, 23'h0}; r.inff = 1'b1;
        end else if (az || bz) begin
            r.z = {sgn, 31'h0}; r.zf = 1'b1;
        end else if (e >= 255) begin
            r.hugef = 1'b1; r.inex = 1'b1;
            to_inf = !(mode == 1 || (mode == 2 && sgn) || (mode == 3 && !sgn));
            if (to_inf) begin r.z = {sgn, 8'hFF, 23'h0}; r.inff = 1'b1; end
            else r.z = {sgn, 8'hFE, 23'h7FFFFF};
        end else if (e <= 0) begin
            r.tinyf = 1'b1; r.inex = 1'b1;
            to_min = (mode == 5) || (mode == 2 && !sgn) || (mode == 3 && sgn);
            if (to_min) r.z = {sgn, 8'h01, 23'h0};
            else begin r.z = {sgn, 31'h0}; r.zf = 1'b1; end
        end else begin
            r.z = {sgn, 8'(e), 23'(q)}; r.inex = inex;
        end
        return r;
    endfunction

    // Scoreboard and handshake monitor, sampled on the falling edge.
    logic        stall_prev = 1'b0;
    logic [31:0] z_prev = '0;
    logic [4:0]  f_prev = '0;

    always @(negedge clk) begin : mon
        exp_t       e;
        logic [4:0] f;
        f = {bus.zero_f, bus.inf_f, bus.nan_f, bus.tiny_f, bus.huge_f};
        if (stall_prev) begin
            check("hold_valid", 64'(bus.out_valid), 64'd1);
            check("hold_z", 64'(bus.z), 64'(z_prev));
            check("hold_flags", 64'(f), 64'(f_prev));
        end
        check("in_ready_rule", 64'(bus.in_ready), 64'(!bus.out_valid || bus.out_ready));
        if (!bus.out_valid) begin
            check("idle_flags", 64'(f), 64'd0);
`ifdef FP_ROUND_INEXACT_EN
            check("idle_inexact", 64'(bus.inexact_f), 64'd0);
`endif
        end
        if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_out: got z=%h with no beat outstanding at %0t", bus.z, $time);
            end else begin
                e = exp_q.pop_front();
                check("z", 64'(bus.z), 64'(e.z));
                check("flags", 64'(f), 64'({e.zf, e.inff, e.nanf, e.tinyf, e.hugef}));
`ifdef FP_ROUND_INEXACT_EN
                check("inexact", 64'(bus.inexact_f), 64'(e.inex));
`endif
            end
        end
        stall_prev = !rst && bus.out_valid && !bus.out_ready;
        z_prev     = bus.z;
        f_prev     = f;
        if (rst) exp_q.delete();
        else if (bus.in_valid && bus.in_ready)
            exp_q.push_back(model(bus.in_sign, int'($signed(bus.in_exp)), bus.in_mant,
                                  {bus.in_a_zero, bus.in_a_inf, bus.in_b_zero, bus.in_b_inf},
                                  int'(bus.rnd)));
    end

    task automatic send(input logic s, input int e, input logic [47:0] m,
                        input logic [3:0] cls, input int mode);
        int guard = 0;
        bus.in_valid = 1'b1;
        bus.in_sign  = s;
        bus.in_exp   = 10'(e);
        bus.in_mant  = m;
        {bus.in_a_zero, bus.in_a_inf, bus.in_b_zero, bus.in_b_inf} = cls;
        bus.rnd      = 3'(mode);
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            guard++;
            if (guard > 50) begin
                checks++; errors++;
                $display("FAIL send_timeout: in_ready stuck at 0, required 1");
                break;
            end
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 100) begin @(negedge clk); guard++; end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d beats outstanding, required 0", exp_q.size());
        end
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 1'b0; bus.in_sign = 1'b0; bus.in_exp = '0; bus.in_mant = '0;
        bus.in_a_zero = 1'b0; bus.in_a_inf = 1'b0; bus.in_b_zero = 1'b0; bus.in_b_inf = 1'b0;
        bus.rnd = '0; bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_z", 64'(bus.z), 64'd0);
        check("rst_flags", 64'({bus.zero_f, bus.inf_f, bus.nan_f, bus.tiny_f, bus.huge_f}), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);

        // Hand-computed pins for the reference model ({z, zero,inf,nan,tiny,huge,inexact}).
        check("pin_normal",   64'(model(0, 127, 48'h900000000000, 4'b0000, 0)), {32'h40100000, 6'b000000});
        check("pin_ovf_near", 64'(model(0, 254, 48'h800000000000, 4'b0000, 0)), {32'h7F800000, 6'b010011});
        check("pin_ovf_zero", 64'(model(0, 254, 48'h800000000000, 4'b0000, 1)), {32'h7F7FFFFF, 6'b000011});
        check("pin_zero_inf", 64'(model(0, 127, 48'h800000000000, 4'b1001, 0)), {32'h7FC00000, 6'b001000});
        check("pin_udf_ninf", 64'(model(1, 0, 48'h400000000000, 4'b0000, 3)),   {32'h80800000, 6'b000101});
        check("pin_udf_near", 64'(model(1, 0, 48'h400000000000, 4'b0000, 0)),   {32'h80000000, 6'b100101});
        check("pin_tie_near", 64'(model(0, 127, 48'h400000400000, 4'b0000, 0)), {32'h3F800000, 6'b000001});
        check("pin_tie_up",   64'(model(0, 127, 48'h400000400000, 4'b0000, 4)), {32'h3F800001, 6'b000001});
        check("pin_carry",    64'(model(0, 127, 48'h7FFFFFFFFFFF, 4'b0000, 0)), {32'h40000000, 6'b000001});
        check("pin_ovf_pinf", 64'(model(1, 254, 48'h800000000000, 4'b0000, 2)), {32'hFF7FFFFF, 6'b000011});

        // Directed vectors through the DUT, back to back.
        send(0, 127, 48'h900000000000, 4'b0000, 0);
        send(0, 254, 48'h800000000000, 4'b0000, 0);
        send(0, 254, 48'h800000000000, 4'b0000, 1);
        send(0, 127, 48'h800000000000, 4'b1001, 0);
        send(1, 127, 48'h800000000000, 4'b0110, 0);
        send(1, 100, 48'h600000000000, 4'b0100, 0);
        send(0, 100, 48'h600000000000, 4'b0010, 0);
        send(1, 0,   48'h400000000000, 4'b0000, 3);
        send(1, 0,   48'h400000000000, 4'b0000, 0);
        send(0, 0,   48'h400000000000, 4'b0000, 5);
        send(0, 127, 48'h400000400000, 4'b0000, 0);
        send(0, 127, 48'h400000400000, 4'b0000, 4);
        send(0, 127, 48'h400000C00000, 4'b0000, 0);
        send(0, 127, 48'h7FFFFFFFFFFF, 4'b0000, 0);
        send(1, 254, 48'h800000000000, 4'b0000, 2);
        send(0, 254, 48'h800000000000, 4'b0000, 3);
        send(1, 254, 48'h7FFFFFFFFFFF, 4'b0000, 0);
        send(0, 1,   48'h400000000000, 4'b0000, 0);
        send(0, -5,  48'h400000000000, 4'b0000, 2);
        send(1, 60,  48'hABCDEF123457, 4'b0000, 2);
        send(1, 60,  48'hABCDEF123457, 4'b0000, 3);
        send(0, 60,  48'hABCDEF123457, 4'b0000, 5);
        drain();

        // Stall: three beats against a blocked consumer, released after three cycles.
        bus.out_ready = 1'b0;
        fork
            begin
                send(0, 130, 48'h500000000000, 4'b0000, 0);
                send(1, 125, 48'hC00000000001, 4'b0000, 5);
                send(0, 128, 48'h4AAAAAAAAAAA, 4'b0000, 0);
            end
            begin
                int g = 0;
                do begin @(negedge clk); g++; end while (!bus.out_valid && g < 20);
                for (int i = 0; i < 3; i++) begin
                    check("stall_in_ready", 64'(bus.in_ready), 64'd0);
                    if (i < 2) @(negedge clk);
                end
                @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
        join
        drain();

        // Mid-stream reset with two beats in flight.
        send(0, 127, 48'h900000000000, 4'b0000, 0);
        send(1, 126, 48'h600000000000, 4'b0000, 0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("flush_out_valid", 64'(bus.out_valid), 64'd0);
        check("flush_flags", 64'({bus.zero_f, bus.inf_f, bus.nan_f, bus.tiny_f, bus.huge_f}), 64'd0);
        check("flush_in_ready", 64'(bus.in_ready), 64'd1);
        repeat (4) @(negedge clk);

        // Throughput with an irregular consumer.
        fork
            begin
                for (int i = 0; i < 16; i++)
                    send(1'(i), 100 + 3 * i, 48'h400000000000 | (48'(i) * 48'h0123456789AB),
                         4'b0000, i % 6);
            end
            begin
                repeat (40) begin @(posedge clk); #1 bus.out_ready = 1'($urandom_range(0, 1)); end
                @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
        join
        drain();

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
